// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: free-running h/v counters advanced on pix_stb,
// with registered sync, active-video, coordinates and one-clk line/frame/vblank strobes.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned CW       = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_stb,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank_start
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CW-1:0] HMax = CW'(HTotal - 1);
  localparam logic [CW-1:0] VMax = CW'(VTotal - 1);

  logic [CW-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic          vblank_start_q, vblank_start_d;

  // Decode in 32-bit space so sync-end bounds equal to 2^CW cannot wrap.
  logic [31:0] h_w, v_w;
  logic        in_hsync, in_vsync, in_active;

  always_comb begin
    h_w       = 32'(h_cnt_q);
    v_w       = 32'(v_cnt_q);
    in_hsync  = (h_w >= H_ACTIVE + H_FP) && (h_w < H_ACTIVE + H_FP + H_SYNC);
    in_vsync  = (v_w >= V_ACTIVE + V_FP) && (v_w < V_ACTIVE + V_FP + V_SYNC);
    in_active = (h_w < H_ACTIVE) && (v_w < V_ACTIVE);
  end

  always_comb begin
    h_cnt_d        = h_cnt_q;
    v_cnt_d        = v_cnt_q;
    hsync_d        = hsync_q;
    vsync_d        = vsync_q;
    active_d       = active_q;
    x_d            = x_q;
    y_d            = y_q;
    line_start_d   = 1'b0;
    frame_start_d  = 1'b0;
    vblank_start_d = 1'b0;
    if (pix_stb) begin
      hsync_d        = in_hsync ? H_POL : ~H_POL;
      vsync_d        = in_vsync ? V_POL : ~V_POL;
      active_d       = in_active;
      x_d            = in_active ? h_cnt_q : '0;
      y_d            = in_active ? v_cnt_q : '0;
      line_start_d   = (h_w == 32'd0);
      frame_start_d  = (h_w == 32'd0) && (v_w == 32'd0);
      vblank_start_d = (h_w == 32'd0) && (v_w == V_ACTIVE);
      if (h_cnt_q == HMax) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == VMax) ? '0 : v_cnt_q + CW'(1);
      end else begin
        h_cnt_d = h_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_q        <= '0;
      v_cnt_q        <= '0;
      hsync_q        <= ~H_POL;
      vsync_q        <= ~V_POL;
      active_q       <= 1'b0;
      x_q            <= '0;
      y_q            <= '0;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
    end else begin
      h_cnt_q        <= h_cnt_d;
      v_cnt_q        <= v_cnt_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      active_q       <= active_d;
      x_q            <= x_d;
      y_q            <= y_d;
      line_start_q   <= line_start_d;
      frame_start_q  <= frame_start_d;
      vblank_start_q <= vblank_start_d;
    end
  end

  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign active       = active_q;
  assign x            = x_q;
  assign y            = y_q;
  assign line_start   = line_start_q;
  assign frame_start  = frame_start_q;
  assign vblank_start = vblank_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small mode (both polarities) and default 640x480 instances
// driven together and checked against an arithmetic raster model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        act;
    logic [10:0] x;
    logic [10:0] y;
    logic        ls;
    logic        fs;
    logic        vbs;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix_stb = 1'b0;
  always #5 clk = ~clk;

  logic        s_hs, s_vs, s_act, s_ls, s_fs, s_vbs;
  logic [10:0] s_x, s_y;
  logic        i_hs, i_vs, i_act, i_ls, i_fs, i_vbs;
  logic [10:0] i_x, i_y;
  logic        d_hs, d_vs, d_act, d_ls, d_fs, d_vbs;
  logic [10:0] d_x, d_y;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .CW(11)
  ) u_small (
    .clk(clk), .reset(reset), .pix_stb(pix_stb), .hsync(s_hs), .vsync(s_vs),
    .active(s_act), .x(s_x), .y(s_y), .line_start(s_ls), .frame_start(s_fs),
    .vblank_start(s_vbs)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .CW(11)
  ) u_inv (
    .clk(clk), .reset(reset), .pix_stb(pix_stb), .hsync(i_hs), .vsync(i_vs),
    .active(i_act), .x(i_x), .y(i_y), .line_start(i_ls), .frame_start(i_fs),
    .vblank_start(i_vbs)
  );

  vga_timing_gen u_def (
    .clk(clk), .reset(reset), .pix_stb(pix_stb), .hsync(d_hs), .vsync(d_vs),
    .active(d_act), .x(d_x), .y(d_y), .line_start(d_ls), .frame_start(d_fs),
    .vblank_start(d_vbs)
  );

  int checks = 0;
  int failures = 0;

  // k: index of the last position presented since reset (-1 = none); flag: last edge strobed.
  int   k = -1;
  bit   flag = 1'b0;
  exp_t e_small, e_inv, e_def;

  function automatic exp_t ref_out(input int kk, input bit fl, input int ha, input int hf,
                                   input int hsw, input int hb, input int va, input int vf,
                                   input int vsw, input int vb, input bit hp, input bit vp);
    exp_t e;
    int ht, vt, h, v;
    e = '0;
    if (kk < 0) begin
      e.hs = !hp;
      e.vs = !vp;
      return e;
    end
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    h = kk % ht;
    v = (kk / ht) % vt;
    e.hs  = (h >= ha + hf && h < ha + hf + hsw) ? hp : !hp;
    e.vs  = (v >= va + vf && v < va + vf + vsw) ? vp : !vp;
    e.act = (h < ha) && (v < va);
    e.x   = e.act ? 11'(h) : 11'd0;
    e.y   = e.act ? 11'(v) : 11'd0;
    e.ls  = fl && (h == 0);
    e.fs  = fl && (h == 0) && (v == 0);
    e.vbs = fl && (h == 0) && (v == va);
    return e;
  endfunction

  function automatic exp_t small_out();
    return '{s_hs, s_vs, s_act, s_x, s_y, s_ls, s_fs, s_vbs};
  endfunction
  function automatic exp_t inv_out();
    return '{i_hs, i_vs, i_act, i_x, i_y, i_ls, i_fs, i_vbs};
  endfunction
  function automatic exp_t def_out();
    return '{d_hs, d_vs, d_act, d_x, d_y, d_ls, d_fs, d_vbs};
  endfunction

  // Apply one clk of stimulus, advance the model, and sample #1 after the edge.
  task automatic step(input bit rst, input bit stb);
    reset   = rst;
    pix_stb = stb;
    @(posedge clk);
    if (rst) begin
      k = -1;
      flag = 1'b0;
    end else if (stb) begin
      k++;
      flag = 1'b1;
    end else begin
      flag = 1'b0;
    end
    #1;
    e_small = ref_out(k, flag, 8, 2, 3, 1, 4, 1, 2, 1, 1'b0, 1'b0);
    e_inv   = ref_out(k, flag, 8, 2, 3, 1, 4, 1, 2, 1, 1'b1, 1'b1);
    e_def   = ref_out(k, flag, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)));
      checks++;
      if (small_out() !== e_small) begin
        failures++;
        $display("FAIL reset_small: got %h want %h", small_out(), e_small);
      end
      checks++;
      if (inv_out() !== e_inv) begin
        failures++;
        $display("FAIL reset_inv: got %h want %h", inv_out(), e_inv);
      end
      checks++;
      if (def_out() !== e_def) begin
        failures++;
        $display("FAIL reset_def: got %h want %h", def_out(), e_def);
      end
    end
  endtask

  task automatic test_full_rate();
    int hs_low = 0, vs_low = 0, fs_cnt = 0, fs_first = -1, fs_second = -1;
    step(1'b1, 1'b0);
    for (int i = 0; i < 224; i++) begin
      step(1'b0, 1'b1);
      checks++;
      if (small_out() !== e_small) begin
        failures++;
        $display("FAIL full_rate_small k=%0d: got %h want %h", k, small_out(), e_small);
      end
      checks++;
      if (inv_out() !== e_inv) begin
        failures++;
        $display("FAIL full_rate_inv k=%0d: got %h want %h", k, inv_out(), e_inv);
      end
      if (s_hs == 1'b0) hs_low++;
      if (s_vs == 1'b0) vs_low++;
      if (s_fs) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = i;
        else if (fs_second < 0) fs_second = i;
      end
    end
    checks++;
    if (hs_low != 48) begin
      failures++;
      $display("FAIL hsync_low_count: got %0d want 48", hs_low);
    end
    checks++;
    if (vs_low != 56) begin
      failures++;
      $display("FAIL vsync_low_count: got %0d want 56", vs_low);
    end
    checks++;
    if (fs_cnt != 2 || fs_second - fs_first != 112) begin
      failures++;
      $display("FAIL frame_period: got count %0d period %0d want 2 / 112", fs_cnt,
               fs_second - fs_first);
    end
  endtask

  task automatic test_slow_strobe();
    int ls_hi = 0, ls_exp = 0, fs_hi = 0, fs_exp = 0;
    bit ls_prev = 1'b0, fs_prev = 1'b0;
    int wide = 0;
    step(1'b1, 1'b0);
    for (int i = 0; i < 4 * 112 + 8; i++) begin
      step(1'b0, (i % 4) == 0);
      checks++;
      if (small_out() !== e_small) begin
        failures++;
        $display("FAIL slow_small k=%0d i=%0d: got %h want %h", k, i, small_out(), e_small);
      end
      checks++;
      if (inv_out() !== e_inv) begin
        failures++;
        $display("FAIL slow_inv k=%0d i=%0d: got %h want %h", k, i, inv_out(), e_inv);
      end
      if (s_ls) ls_hi++;
      if (e_small.ls) ls_exp++;
      if (s_fs) fs_hi++;
      if (e_small.fs) fs_exp++;
      if ((s_ls && ls_prev) || (s_fs && fs_prev)) wide++;
      ls_prev = s_ls;
      fs_prev = s_fs;
    end
    checks++;
    if (ls_hi != ls_exp || fs_hi != fs_exp || wide != 0) begin
      failures++;
      $display("FAIL strobe_width: got ls=%0d fs=%0d wide=%0d want ls=%0d fs=%0d wide=0",
               ls_hi, fs_hi, wide, ls_exp, fs_exp);
    end
  endtask

  task automatic test_mid_reset();
    step(1'b1, 1'b0);
    while (k < 32) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    checks++;
    if (small_out() !== e_small) begin
      failures++;
      $display("FAIL mid_reset_values: got %h want %h", small_out(), e_small);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    checks++;
    if (s_act !== 1'b1 || s_x !== 11'd0 || s_y !== 11'd0 || s_ls !== 1'b1 || s_fs !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_restart: got act=%b x=%0d y=%0d ls=%b fs=%b want 1 0 0 1 1",
               s_act, s_x, s_y, s_ls, s_fs);
    end
    checks++;
    if (inv_out() !== e_inv) begin
      failures++;
      $display("FAIL mid_reset_inv: got %h want %h", inv_out(), e_inv);
    end
  endtask

  task automatic test_random();
    step(1'b1, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 599) == 0, $urandom_range(0, 2) != 0);
      checks++;
      if (small_out() !== e_small) begin
        failures++;
        $display("FAIL random_small k=%0d: got %h want %h", k, small_out(), e_small);
      end
      checks++;
      if (inv_out() !== e_inv) begin
        failures++;
        $display("FAIL random_inv k=%0d: got %h want %h", k, inv_out(), e_inv);
      end
      checks++;
      if (def_out() !== e_def) begin
        failures++;
        $display("FAIL random_def k=%0d: got %h want %h", k, def_out(), e_def);
      end
    end
  endtask

  task automatic test_default_lines();
    int hs_low = 0, ls_first = -1, ls_second = -1;
    step(1'b1, 1'b0);
    for (int i = 0; i < 1700; i++) begin
      step(1'b0, 1'b1);
      checks++;
      if (def_out() !== e_def) begin
        failures++;
        $display("FAIL default_lines k=%0d: got %h want %h", k, def_out(), e_def);
      end
      if (i < 800 && d_hs == 1'b0) hs_low++;
      if (d_ls) begin
        if (ls_first < 0) ls_first = i;
        else if (ls_second < 0) ls_second = i;
      end
      if (k == 639) begin
        checks++;
        if (d_x !== 11'd639 || d_act !== 1'b1) begin
          failures++;
          $display("FAIL default_last_col: got x=%0d act=%b want 639 1", d_x, d_act);
        end
      end
    end
    checks++;
    if (ls_second - ls_first != 800) begin
      failures++;
      $display("FAIL default_line_period: got %0d want 800", ls_second - ls_first);
    end
    checks++;
    if (hs_low != 96) begin
      failures++;
      $display("FAIL default_hsync_width: got %0d want 96", hs_low);
    end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_slow_strobe();
    test_mid_reset();
    test_random();
    test_default_lines();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
